// File: rtl/ant_update_sequencer_pkg.sv
// Shared configuration for the ant-routing blocks: default sizes, pheromone
// bounds, the sequencer state encoding and a drop-check helper.
package ant_update_sequencer_pkg;

    localparam int DEFAULT_N        = 5;
    localparam int DEFAULT_NODES    = 16;
    localparam int DEFAULT_MAX_HOPS = 8;

    localparam logic [15:0] PH_MIN_VALUE = 16'h0001;
    localparam logic [15:0] PH_MAX_VALUE = 16'hFF00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UPDATE  = 2'd1,
        ST_FORWARD = 2'd2
    } ant_state_e;

    // An ant is unusable if it claims to arrive on the local port, on a port
    // that does not exist, or carries more return hops than the stack holds.
    function automatic logic ant_is_bad(input int unsigned port,
                                        input int unsigned ptr,
                                        input int unsigned n_ports,
                                        input int unsigned max_hops);
        return (port == 32'd0) || (port >= n_ports) || (ptr > max_hops);
    endfunction

endpackage

// File: rtl/ant_update_sequencer_stack_pop.sv
// Pops the top entry of a backward ant's return-port stack: returns the
// entry at ptr-1, the stack with that entry cleared, and the new pointer.
module ant_path_stack_pop #(
    parameter int PW       = 3,
    parameter int MAX_HOPS = 8,
    parameter int PTRW     = $clog2(MAX_HOPS + 1)
) (
    input  logic [MAX_HOPS*PW-1:0] stack_in,
    input  logic [PTRW-1:0]        ptr_in,
    output logic [PW-1:0]          port_out,
    output logic [MAX_HOPS*PW-1:0] stack_out,
    output logic [PTRW-1:0]        ptr_out
);

    // Select and clear the top-of-stack entry; an empty stack pops nothing.
    always_comb begin
        port_out  = '0;
        stack_out = stack_in;
        ptr_out   = '0;
        if (ptr_in != '0) begin
            ptr_out = ptr_in - PTRW'(1);
            for (int k = 0; k < MAX_HOPS; k++) begin
                if (PTRW'(k) == ptr_out) begin
                    port_out              = stack_in[k*PW +: PW];
                    stack_out[k*PW +: PW] = '0;
                end else begin
                    stack_out[k*PW +: PW] = stack_in[k*PW +: PW];
                end
            end
        end else begin
            ptr_out = '0;
        end
    end

endmodule

// File: rtl/ant_update_sequencer.sv
// Backward-ant sequencer: accepts one ant, issues a single routing-table
// update for its origin, then forwards the ant one hop back along its path.
module ant_update_sequencer
    import ant_update_sequencer_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int NODES    = DEFAULT_NODES,
    parameter int MAX_HOPS = DEFAULT_MAX_HOPS,
    parameter int PW       = $clog2(N)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_ant_valid,
    input  logic [N-1:0]           i_ant_src,
    input  logic [PW-1:0]          i_ant_port,
    input  logic [MAX_HOPS*PW-1:0] i_ant_stack,
    input  logic [$clog2(MAX_HOPS+1)-1:0] i_ant_ptr,
    output logic                   o_ant_ready,
    input  logic                   i_table_busy,
    output logic                   o_update,
    output logic [N-1:0]           o_dest,
    output logic [N-1:0]           o_parent,
    output logic                   o_fwd_valid,
    input  logic                   i_fwd_ready,
    output logic [PW-1:0]          o_fwd_port,
    output logic [MAX_HOPS*PW-1:0] o_fwd_stack,
    output logic [$clog2(MAX_HOPS+1)-1:0] o_fwd_ptr,
    output logic                   o_done,
    output logic                   o_err,
    output logic [15:0]            o_update_count
);

    localparam int PTRW = $clog2(MAX_HOPS + 1);

    ant_state_e             state_r, state_s;
    logic [N-1:0]           src_r, cur_src_s;
    logic [PW-1:0]          port_r, cur_port_s;
    logic [MAX_HOPS*PW-1:0] stack_r;
    logic [PTRW-1:0]        ptr_r;
    logic                   ready_r, update_r, fwd_valid_r, done_r, err_r;
    logic [N-1:0]           dest_r, parent_r;
    logic [PW-1:0]          fwd_port_r;
    logic [MAX_HOPS*PW-1:0] fwd_stack_r;
    logic [PTRW-1:0]        fwd_ptr_r;
    logic [15:0]            update_count_r;

    logic                   latch_s, update_s, fwd_valid_s, done_s, err_s;
    logic [PW-1:0]          pop_port_s;
    logic [MAX_HOPS*PW-1:0] pop_stack_s;
    logic [PTRW-1:0]        pop_ptr_s;

    ant_path_stack_pop #(
        .PW       (PW),
        .MAX_HOPS (MAX_HOPS),
        .PTRW     (PTRW)
    ) u_pop (
        .stack_in  (stack_r),
        .ptr_in    (ptr_r),
        .port_out  (pop_port_s),
        .stack_out (pop_stack_s),
        .ptr_out   (pop_ptr_s)
    );

    // Next-state and next-output decode; outputs are registered one edge later.
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        update_s    = 1'b0;
        fwd_valid_s = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ready_r && i_ant_valid) begin
                    if (ant_is_bad(32'(i_ant_port), 32'(i_ant_ptr), N, MAX_HOPS)) begin
                        err_s = 1'b1;
                    end else begin
                        latch_s  = 1'b1;
                        state_s  = ST_UPDATE;
                        update_s = !i_table_busy;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (update_r) begin
                    if (ptr_r == '0) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        fwd_valid_s = 1'b1;
                        state_s     = ST_FORWARD;
                    end
                end else begin
                    update_s = !i_table_busy;
                end
            end
            ST_FORWARD: begin
                if (i_fwd_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    fwd_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // The update can fire on the accepting edge, before src/port are latched.
        if (latch_s) begin
            cur_src_s  = i_ant_src;
            cur_port_s = i_ant_port;
        end else begin
            cur_src_s  = src_r;
            cur_port_s = port_r;
        end
    end

    // State register, held ant fields and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            src_r       <= '0;
            port_r      <= '0;
            stack_r     <= '0;
            ptr_r       <= '0;
            ready_r     <= 1'b0;
            update_r    <= 1'b0;
            dest_r      <= '0;
            parent_r    <= '0;
            fwd_valid_r <= 1'b0;
            fwd_port_r  <= '0;
            fwd_stack_r <= '0;
            fwd_ptr_r   <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ready_r     <= (state_s == ST_IDLE);
            update_r    <= update_s;
            dest_r      <= update_s ? cur_src_s : '0;
            parent_r    <= update_s ? N'(cur_port_s) : '0;
            fwd_valid_r <= fwd_valid_s;
            fwd_port_r  <= fwd_valid_s ? pop_port_s  : '0;
            fwd_stack_r <= fwd_valid_s ? pop_stack_s : '0;
            fwd_ptr_r   <= fwd_valid_s ? pop_ptr_s   : '0;
            done_r      <= done_s;
            err_r       <= err_s;
            if (latch_s) begin
                src_r   <= i_ant_src;
                port_r  <= i_ant_port;
                stack_r <= i_ant_stack;
                ptr_r   <= i_ant_ptr;
            end
        end
    end

    // Saturating count of issued table updates.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            update_count_r <= 16'h0000;
        end else if (update_s && (update_count_r != 16'hFFFF)) begin
            update_count_r <= update_count_r + 16'd1;
        end
    end

    assign o_ant_ready    = ready_r;
    assign o_update       = update_r;
    assign o_dest         = dest_r;
    assign o_parent       = parent_r;
    assign o_fwd_valid    = fwd_valid_r;
    assign o_fwd_port     = fwd_port_r;
    assign o_fwd_stack    = fwd_stack_r;
    assign o_fwd_ptr      = fwd_ptr_r;
    assign o_done         = done_r;
    assign o_err          = err_r;
    assign o_update_count = update_count_r;

endmodule

// File: doc/ant_update_sequencer.md
ANT_UPDATE_SEQUENCER -- requirements
Module: ant_update_sequencer

Interface
REQ-001 SHALL have parameters: N, default `N (router ports; port 0 = local), meaning port count; NODES, default `NODES, meaning node count; MAX_HOPS, default 8, meaning backward-ant path stack depth; PW = $clog2(N), meaning port-index width.
REQ-002 SHALL have ports: i_clk in 1 clock; i_reset_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have input ports: i_ant_valid in 1 (backward ant offered); i_ant_src in N (origin node id, zero-extended, pheromone destination key); i_ant_port in PW (arrival port); i_ant_stack in MAX_HOPS*PW (return-port stack, entry k at bits [k*PW +: PW]); i_ant_ptr in $clog2(MAX_HOPS+1) (valid entries).
REQ-004 SHALL have port o_ant_ready out 1 (ant accepted when high with valid).
REQ-005 SHALL have table-side ports: i_table_busy in 1 (table evaluating i_calculate_neighbor); o_update out 1; o_dest out N; o_parent out N (routing-table update command).
REQ-006 SHALL have forward-side ports: o_fwd_valid out 1; i_fwd_ready in 1; o_fwd_port out PW; o_fwd_stack out MAX_HOPS*PW; o_fwd_ptr out $clog2(MAX_HOPS+1).
REQ-007 SHALL have status ports: o_done out 1 (ant reached origin, consumed); o_err out 1 (ant dropped); o_update_count out 16 (updates issued).

Function
REQ-008 SHALL implement FSM states IDLE, UPDATE, FORWARD.
REQ-009 IDLE: o_ant_ready=1; on i_ant_valid latch all ant fields, go UPDATE; no other state asserts o_ant_ready.
REQ-010 Ant with i_ant_port==0 or i_ant_port>=N SHALL be accepted, dropped, o_err pulsed one cycle, no update issued, stay IDLE.
REQ-011 Ant with i_ant_ptr>MAX_HOPS SHALL be handled as REQ-010.
REQ-012 UPDATE: when i_table_busy=0, assert o_update for exactly one cycle with o_dest=latched src, o_parent=latched arrival port zero-extended to N; while i_table_busy=1, o_update=0 and state holds.
REQ-013 After the update cycle: ptr==0 -> pulse o_done one cycle, go IDLE; ptr>0 -> go FORWARD.
REQ-014 FORWARD: o_fwd_valid=1, o_fwd_port=stack[ptr-1], o_fwd_ptr=ptr-1, o_fwd_stack=latched stack with entry ptr-1 zeroed; fields stable until i_fwd_ready=1, then go IDLE.
REQ-015 Latency: accept at cycle t, o_update at t+1 (not busy), o_fwd_valid from t+2; next ant accepted no earlier than cycle after fwd handshake/done.
REQ-016 o_update_count SHALL increment per o_update cycle, saturating at 16'hFFFF.
REQ-017 o_dest, o_parent SHALL be 0 whenever o_update=0; o_fwd_* SHALL be 0 whenever o_fwd_valid=0.
REQ-018 i_fwd_ready outside FORWARD and i_ant_valid outside IDLE SHALL be ignored.

Reset
REQ-019 Asserting i_reset_n low at any time, including mid-UPDATE or mid-FORWARD, SHALL force IDLE and discard the held ant.
REQ-020 Reset values: o_ant_ready=1 only after reset deasserts (0 while in reset), all other outputs 0, o_update_count=0.

Structure
REQ-021 N, NODES, MAX_HOPS defaults and the state enum SHALL live in the shared config package alongside PH_MIN_VALUE/PH_MAX_VALUE.
REQ-022 Stack pop logic SHALL be one sub-module ant_path_stack_pop (combinational, stack+ptr in, port+stack+ptr out).
REQ-023 Outputs SHALL be registered; no combinational path from i_table_busy or i_fwd_ready to any output.

Verification
REQ-024 Ant src=5, port=2, ptr=3, stack={1,4,3}, busy=0, fwd_ready=1 -> o_update cycle t+1, dest=5, parent=2; o_fwd_port=3, o_fwd_ptr=2 at t+2; count=1.
REQ-025 Same ant, i_table_busy high 4 cycles -> o_update delayed exactly 4 cycles, single pulse.
REQ-026 Ant ptr=0, port=1 -> one update, o_done pulse, no o_fwd_valid.
REQ-027 Ant port=0, then port=N -> o_err pulses, count unchanged, o_update never asserted.
REQ-028 i_fwd_ready low 10 cycles in FORWARD -> o_fwd_* stable, o_ant_ready low; reset asserted mid-FORWARD -> all outputs 0, IDLE, next ant accepted.
REQ-029 Force count to 16'hFFFE, issue 3 updates -> count stops at 16'hFFFF.
